// File: rtl/spi_target_if.sv
// SPI mode-0 pin bundle between a controller and an spi_target.
interface spi_target_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;

  modport master (output sclk, output cs_n, output mosi, input miso);
  modport slave  (input sclk, input cs_n, input mosi, output miso);
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 target: oversamples the SPI pins on clk, writes every received byte
// to an attached byte memory and returns that memory's contents on miso.
module spi_target #(
  parameter int MEMORY_SIZE_IN_BYTES = 64,
  parameter int SYNC_STAGES          = 2,
  localparam int AW                  = $clog2(MEMORY_SIZE_IN_BYTES)
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_target_if.slave   spi,
  input  logic [7:0]    data_in,
  output logic [7:0]    data_out,
  output logic          wr,
  output logic [AW-1:0] address,
  output logic [AW-1:0] byte_count,
  output logic          frame_done
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, WRITE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [6:0]    rx_shift, tx_shift;
  logic          have_byte, miso_q;
  logic [AW-1:0] address_next, count_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  assign address_next = (address == AW'(MEMORY_SIZE_IN_BYTES - 1)) ? '0 : address + 1'b1;
  assign count_next   = (byte_count == AW'(MEMORY_SIZE_IN_BYTES - 1)) ? '0 : byte_count + 1'b1;
  assign spi.miso     = miso_q;

  // Deselect parks address at 0 so the next LOAD already sees memory[0] on data_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      have_byte  <= 1'b0;
      miso_q     <= 1'b1;
      wr         <= 1'b0;
      frame_done <= 1'b0;
      data_out   <= '0;
      address    <= '0;
      byte_count <= '0;
    end else begin
      wr         <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          miso_q <= 1'b1;
          if (cs_fall) state <= LOAD;
        end
        LOAD: begin
          address    <= '0;
          byte_count <= '0;
          bit_cnt    <= '0;
          have_byte  <= 1'b0;
          rx_shift   <= '0;
          miso_q     <= data_in[7];
          tx_shift   <= data_in[6:0];
          if (cs_rise) begin
            state      <= IDLE;
            miso_q     <= 1'b1;
            frame_done <= 1'b1;
          end else begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state      <= IDLE;
            miso_q     <= 1'b1;
            frame_done <= 1'b1;
            bit_cnt    <= '0;
            address    <= '0;
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[5:0], mosi_s};
            if (bit_cnt == 3'd7) begin
              data_out <= {rx_shift, mosi_s};
              bit_cnt  <= '0;
              wr       <= 1'b1;
              state    <= WRITE;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else if (sclk_fall) begin
            if (bit_cnt != 3'd0) begin
              miso_q   <= tx_shift[6];
              tx_shift <= {tx_shift[5:0], 1'b0};
            end else if (have_byte) begin
              miso_q   <= data_in[7];
              tx_shift <= data_in[6:0];
            end
          end
        end
        WRITE: begin
          address    <= address_next;
          byte_count <= count_next;
          have_byte  <= 1'b1;
          if (cs_rise) begin
            state      <= IDLE;
            miso_q     <= 1'b1;
            frame_done <= 1'b1;
            address    <= '0;
          end else begin
            state <= SHIFT;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: a 64-byte instance for the main scenarios and a 4-byte
// instance for address wrap, both checked against a byte-level memory model.
`timescale 1ns/1ps
module tb_spi_target;

  typedef struct packed {
    logic [7:0] cnt;
    logic [7:0] addr;
    logic [7:0] data;
  } wr_rec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic sclk, mosi, cs_m, cs_w;

  int tests_run = 0;
  int tests_failed = 0;

  spi_target_if bus_m ();
  spi_target_if bus_w ();

  assign bus_m.sclk = sclk;
  assign bus_m.mosi = mosi;
  assign bus_m.cs_n = cs_m;
  assign bus_w.sclk = sclk;
  assign bus_w.mosi = mosi;
  assign bus_w.cs_n = cs_w;

  logic [7:0] data_in_m, data_out_m, data_in_w, data_out_w;
  logic       wr_m, fd_m, wr_w, fd_w;
  logic [5:0] address_m, byte_count_m;
  logic [1:0] address_w, byte_count_w;

  spi_target #(.MEMORY_SIZE_IN_BYTES(64), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .spi(bus_m), .data_in(data_in_m), .data_out(data_out_m),
    .wr(wr_m), .address(address_m), .byte_count(byte_count_m), .frame_done(fd_m)
  );

  spi_target #(.MEMORY_SIZE_IN_BYTES(4), .SYNC_STAGES(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .spi(bus_w), .data_in(data_in_w), .data_out(data_out_w),
    .wr(wr_w), .address(address_w), .byte_count(byte_count_w), .frame_done(fd_w)
  );

  always #5 clk = ~clk;

  // Attached memories with a one-cycle read; preload goes through the same process.
  logic [7:0] mem_m [64];
  logic [7:0] mem_w [4];
  logic       pl_en;
  int         pl_inst;
  logic [7:0] pl_addr, pl_data;

  always @(posedge clk) begin
    if (pl_en && pl_inst == 0) mem_m[pl_addr[5:0]] <= pl_data;
    else if (wr_m) mem_m[address_m] <= data_out_m;
    if (pl_en && pl_inst == 1) mem_w[pl_addr[1:0]] <= pl_data;
    else if (wr_w) mem_w[address_w] <= data_out_w;
    data_in_m <= mem_m[address_m];
    data_in_w <= mem_w[address_w];
  end

  logic       wr_v [2], fd_v [2], miso_v [2];
  logic [7:0] addr_v [2], cnt_v [2], dout_v [2];

  assign wr_v[0]   = wr_m;
  assign wr_v[1]   = wr_w;
  assign fd_v[0]   = fd_m;
  assign fd_v[1]   = fd_w;
  assign miso_v[0] = bus_m.miso;
  assign miso_v[1] = bus_w.miso;
  assign addr_v[0] = 8'(address_m);
  assign addr_v[1] = 8'(address_w);
  assign cnt_v[0]  = 8'(byte_count_m);
  assign cnt_v[1]  = 8'(byte_count_w);
  assign dout_v[0] = data_out_m;
  assign dout_v[1] = data_out_w;

  // Model: memory image per instance plus queues of expected writes and frame ends.
  logic [7:0] mdl [2][64];
  wr_rec_t    wq [2][$];
  logic [7:0] fq [2][$];
  logic [7:0] frame_data [8];
  logic [7:0] rx_bytes [8];

  function automatic int sizeOf(input int i);
    return (i == 0) ? 64 : 4;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  logic       pend [2];
  logic [7:0] pend_addr [2], pend_cnt [2];
  wr_rec_t    cmp_rec;

  // Every write must match the next modelled byte; the following cycle shows the advanced pointers.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend[0] = 1'b0;
      pend[1] = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (pend[i]) begin
          checkOutput($sformatf("addr_after_wr[%0d]", i), addr_v[i], pend_addr[i]);
          checkOutput($sformatf("count_after_wr[%0d]", i), cnt_v[i], pend_cnt[i]);
          pend[i] = 1'b0;
        end
        if (wr_v[i]) begin
          if (wq[i].size() == 0) begin
            checkOutput($sformatf("unexpected_wr[%0d]", i), 32'(wr_v[i]), 0);
          end else begin
            cmp_rec = wq[i].pop_front();
            checkOutput($sformatf("wr_addr[%0d]", i), addr_v[i], cmp_rec.addr);
            checkOutput($sformatf("wr_data[%0d]", i), dout_v[i], cmp_rec.data);
            pend[i]      = 1'b1;
            pend_addr[i] = 8'((int'(cmp_rec.addr) + 1) % sizeOf(i));
            pend_cnt[i]  = cmp_rec.cnt;
          end
        end
        if (fd_v[i]) begin
          if (fq[i].size() == 0) checkOutput($sformatf("unexpected_frame_done[%0d]", i), 32'(fd_v[i]), 0);
          else checkOutput($sformatf("frame_byte_count[%0d]", i), cnt_v[i], fq[i].pop_front());
        end
      end
    end
  end

  task automatic loadMem(input int i, input int addr, input logic [7:0] val);
    pl_inst = i;
    pl_addr = 8'(addr);
    pl_data = val;
    pl_en   = 1'b1;
    mdl[i][addr] = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic setCs(input int i, input logic v);
    if (i == 0) cs_m = v;
    else cs_w = v;
  endtask

  // One frame at clk/8: nbytes full bytes, then `partial` extra bits, then optional deselect.
  task automatic applyStimulus(input int i, input int nbytes, input int partial, input bit deselect);
    int         n, bits;
    logic [7:0] rx, exp_miso;
    wr_rec_t    rec;
    n = sizeOf(i);
    @(negedge clk);
    setCs(i, 1'b0);
    repeat (6) @(negedge clk);
    for (int k = 0; k < nbytes + ((partial > 0) ? 1 : 0); k++) begin
      bits     = (k < nbytes) ? 8 : partial;
      exp_miso = mdl[i][k % n];
      rx       = '0;
      for (int b = 0; b < bits; b++) begin
        mosi = frame_data[k][7-b];
        repeat (4) @(negedge clk);
        rx = {rx[6:0], miso_v[i]};
        if (b == 7) begin
          rec.cnt  = 8'((k + 1) % n);
          rec.addr = 8'(k % n);
          rec.data = frame_data[k];
          wq[i].push_back(rec);
          mdl[i][k % n] = frame_data[k];
        end
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
      end
      if (bits == 8) begin
        rx_bytes[k] = rx;
        checkOutput($sformatf("miso_byte%0d[%0d]", k, i), rx, exp_miso);
      end
    end
    if (deselect) begin
      repeat (6) @(negedge clk);
      fq[i].push_back(8'(nbytes % n));
      setCs(i, 1'b1);
      repeat (10) @(negedge clk);
      checkOutput($sformatf("miso_idle[%0d]", i), 32'(miso_v[i]), 1);
      checkOutput($sformatf("writes_outstanding[%0d]", i), wq[i].size(), 0);
      checkOutput($sformatf("frame_done_outstanding[%0d]", i), fq[i].size(), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: run exceeded its time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0;
    sclk  = 1'b0;
    mosi  = 1'b0;
    cs_m  = 1'b1;
    cs_w  = 1'b1;
    pl_en = 1'b0;
    pl_inst = 0;
    pl_addr = '0;
    pl_data = '0;
    for (int j = 0; j < 64; j++) begin
      mdl[0][j] = '0;
      mdl[1][j] = '0;
    end

    @(negedge clk);
    checkOutput("reset_miso", 32'(bus_m.miso), 1);
    checkOutput("reset_wr", 32'(wr_m), 0);
    checkOutput("reset_frame_done", 32'(fd_m), 0);
    checkOutput("reset_data_out", data_out_m, 0);
    checkOutput("reset_address", address_m, 0);
    checkOutput("reset_byte_count", byte_count_m, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 64; j++) loadMem(0, j, 8'h00);
    for (int j = 0; j < 4; j++) loadMem(1, j, 8'h00);

    $display("[TB] single byte");
    loadMem(0, 0, 8'hA5);
    frame_data[0] = 8'h3C;
    applyStimulus(0, 1, 0, 1'b1);
    checkOutput("single_miso_literal", rx_bytes[0], 8'hA5);
    checkOutput("single_data_out_literal", data_out_m, 8'h3C);
    checkOutput("single_count_literal", byte_count_m, 1);

    $display("[TB] three bytes");
    loadMem(0, 0, 8'h11);
    loadMem(0, 1, 8'h22);
    loadMem(0, 2, 8'h33);
    frame_data[0] = 8'hDE;
    frame_data[1] = 8'hAD;
    frame_data[2] = 8'hBE;
    applyStimulus(0, 3, 0, 1'b1);
    checkOutput("three_miso0_literal", rx_bytes[0], 8'h11);
    checkOutput("three_miso1_literal", rx_bytes[1], 8'h22);
    checkOutput("three_miso2_literal", rx_bytes[2], 8'h33);
    checkOutput("three_count_literal", byte_count_m, 3);

    $display("[TB] abort after 5 bits of second byte");
    loadMem(0, 0, 8'h5A);
    loadMem(0, 1, 8'hC3);
    frame_data[0] = 8'h77;
    frame_data[1] = 8'h99;
    applyStimulus(0, 1, 5, 1'b1);
    checkOutput("abort_count_literal", byte_count_m, 1);
    checkOutput("abort_data_out_literal", data_out_m, 8'h77);
    frame_data[0] = 8'h42;
    applyStimulus(0, 1, 0, 1'b1);
    checkOutput("restart_miso_literal", rx_bytes[0], 8'h77);

    $display("[TB] empty frame");
    @(negedge clk);
    cs_m = 1'b0;
    repeat (20) @(negedge clk);
    fq[0].push_back(8'h00);
    cs_m = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("empty_count_literal", byte_count_m, 0);
    checkOutput("empty_miso_literal", 32'(bus_m.miso), 1);
    checkOutput("empty_frame_done_seen", fq[0].size(), 0);

    $display("[TB] wrap on 4-byte instance");
    loadMem(1, 0, 8'h01);
    loadMem(1, 1, 8'h02);
    loadMem(1, 2, 8'h03);
    loadMem(1, 3, 8'h04);
    for (int j = 0; j < 5; j++) frame_data[j] = 8'hA0 + 8'(j);
    applyStimulus(1, 5, 0, 1'b1);
    checkOutput("wrap_miso3_literal", rx_bytes[3], 8'h04);
    checkOutput("wrap_miso4_literal", rx_bytes[4], 8'hA0);
    checkOutput("wrap_count_literal", byte_count_w, 1);

    $display("[TB] reset mid-frame");
    loadMem(0, 0, 8'h3E);
    loadMem(0, 1, 8'h81);
    frame_data[0] = 8'h66;
    frame_data[1] = 8'h99;
    applyStimulus(0, 1, 3, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_miso", 32'(bus_m.miso), 1);
    checkOutput("midreset_wr", 32'(wr_m), 0);
    checkOutput("midreset_address", address_m, 0);
    checkOutput("midreset_byte_count", byte_count_m, 0);
    checkOutput("midreset_data_out", data_out_m, 0);
    @(negedge clk);
    cs_m = 1'b1;
    sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("post_reset_writes_pending", wq[0].size(), 0);
    checkOutput("post_reset_miso", 32'(bus_m.miso), 1);

    loadMem(0, 0, 8'hF0);
    frame_data[0] = 8'h0F;
    applyStimulus(0, 1, 0, 1'b1);
    checkOutput("post_reset_miso_literal", rx_bytes[0], 8'hF0);
    checkOutput("post_reset_count_literal", byte_count_m, 1);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_target.md
# spi_target

SPI mode-0 (CPOL=0, CPHA=0) target that sits on the far side of our SPI controller, for SD-card emulation and loop-back benches. It oversamples `sclk`/`cs_n`/`mosi` on the system clock. Every received byte is written into a byte memory. In the same frame, the byte at the current memory address is shifted out on `miso`. Each frame starts at address 0 and advances one address per completed byte.

## Interface
- `MEMORY_SIZE_IN_BYTES`, 64: depth of the attached byte memory. `AW = $clog2(MEMORY_SIZE_IN_BYTES)`.
- `SYNC_STAGES`, 2: synchroniser depth for `sclk`, `cs_n` and `mosi`. Must be ≥2.
- `clk` in 1: system clock. This is the only clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `sclk` in 1: SPI clock from the controller. Asynchronous to `clk`.
- `cs_n` in 1: chip select, active-low, asynchronous.
- `mosi` in 1: controller-to-target data, MSB first.
- `miso` out 1: target-to-controller data, MSB first.
- `data_in` in 8: memory read data at `address`. Combinational or 1-cycle read.
- `data_out` out 8: last fully received byte.
- `wr` out 1: one-cycle write strobe. Writes `data_out` to memory at `address`.
- `address` out AW: current byte index in the frame.
- `byte_count` out AW: number of complete bytes in the current or last frame, modulo `MEMORY_SIZE_IN_BYTES`.
- `frame_done` out 1: one-cycle pulse when `cs_n` deasserts.

## Operation
- **Synchronisers:** `sclk`, `cs_n` and `mosi` each pass through `SYNC_STAGES` flops.
- **Edge detection:** a rise or fall is detected by comparing the synchronised `sclk` with a one-cycle-delayed copy. The synchronised `cs_n` is treated the same way.
- **States:** IDLE, LOAD, SHIFT, WRITE.
- **IDLE:**
  - `miso`=1, `wr`=0, `address` holds.
  - A synchronised `cs_n` fall moves to LOAD.
- **LOAD (one cycle):**
  - `address`←0, `byte_count`←0, bit counter←0.
  - `miso`←`data_in[7]`, tx shift←`data_in[6:0]`.
  - Moves to SHIFT.
- **SHIFT:**
  - On an `sclk` rise: rx shift←{rx[6:0], synced `mosi`}, bit counter+1.
  - On the 8th rise: `data_out`←completed byte, bit counter←0, move to WRITE.
  - On an `sclk` fall with bit counter≠0: `miso`←next tx bit.
  - On an `sclk` fall with bit counter=0, after ≥1 completed byte: reload `miso`←`data_in[7]` and tx←`data_in[6:0]` from the new address.
- **WRITE (one cycle):**
  - `wr`=1 at the old `address`.
  - At exit: `address`+1 and `byte_count`+1, both wrapping modulo `MEMORY_SIZE_IN_BYTES`.
  - Moves to SHIFT.
- **Deselect:** a synchronised `cs_n` rise in any non-IDLE state:
  - Discard partial bits; no `wr` is issued for them.
  - `frame_done` pulses for one cycle.
  - Go to IDLE; `miso`←1.
  - `byte_count` and `data_out` hold until the next LOAD.
- **Deselect during WRITE:** the write completes first, then the deselect is handled.
- **Empty frame:** a `cs_n` fall followed by a rise with zero `sclk` edges still pulses `frame_done`, with `byte_count`=0.
- **`sclk` edges while `cs_n` is high:** ignored.
- **Asynchronous reset**, any time including mid-frame:
  - All outputs go to their reset values and the state goes to IDLE; no `wr` is issued.
  - Synchroniser flops reset to `sclk`=0, `cs_n`=1, `mosi`=0.

## Timing
- **Reset values:**
  - `miso`=1, `wr`=0, `frame_done`=0.
  - `data_out`=0, `address`=0, `byte_count`=0.
- **Edge latency:** an edge on an input pin is detected in the cycle `SYNC_STAGES`+1 after it appears on the pin.
- **Byte completion:** let E be the detect cycle of the 8th `sclk` rise.
  - Cycle E+1: `data_out` valid and `wr`=1.
  - Cycle E+2: `address` and `byte_count` hold their incremented values.
- **First bit:** `miso` carries bit 7 of memory[0] starting `SYNC_STAGES`+2 cycles after the `cs_n` fall.
- **`data_in` sampling:** `data_in` is sampled in LOAD and on a reload fall. Both occur ≥2 cycles after the last `address` change, so memory read latency must be ≤1 cycle.
- **Controller constraints:**
  - `sclk` frequency ≤ `clk`/8, with each half-period ≥4 `clk` cycles.
  - `cs_n` setup before the first `sclk` rise and hold after the last `sclk` fall must each be ≥4 `clk` cycles.
- **`miso` timing:** `miso` changes only on detected `sclk` falls, in LOAD, or on deselect. It is stable around every rise.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream. Expect `miso`=1, `wr`=0, `address`=0, `byte_count`=0 and `data_out`=0 immediately, with no `wr` after release.
- **Single byte:** memory[0]=0xA5; controller sends 0x3C at `clk`/8. Expect:
  - `miso` bits sampled on the rises are 1,0,1,0,0,1,0,1.
  - One `wr` with `address`=0 and `data_out`=0x3C.
  - `frame_done` pulse and `byte_count`=1.
- **Three bytes:** memory = 0x11, 0x22, 0x33; send 0xDE, 0xAD, 0xBE. Expect:
  - Received `miso` bytes 0x11, 0x22, 0x33.
  - Writes 0xDE@0, 0xAD@1, 0xBE@2.
  - `byte_count`=3.
- **Abort:** raise `cs_n` after 5 bits of the second byte. Expect:
  - Exactly one `wr` (@0), `frame_done` pulse, `byte_count`=1, state IDLE.
  - The next frame restarts at `address` 0.
- **Wrap:** with `MEMORY_SIZE_IN_BYTES`=4, send 5 bytes. Expect the 5th `wr` at `address` 0 and final `byte_count`=1.
- **Empty frame:** `cs_n` pulse of 20 cycles with no `sclk`. Expect one `frame_done`, `byte_count`=0, no `wr`, and `miso` back to 1.
